// File: rtl/ring_freq_meter_pkg.sv
// Shared definitions for the ring oscillator frequency meter and its benches.
`timescale 1ps/1ps
package ring_pkg;

   // Measurement sequencer states
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_MEASURE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   // Default measurement setup, also used by the ring oscillator bench
   localparam int DEF_GATE_CYCLES   = 1000;
   localparam int DEF_SETTLE_CYCLES = 64;
   localparam int DEF_CNT_W         = 16;
   localparam int DEF_SYNC_STAGES   = 2;

endpackage

// File: rtl/ring_freq_meter_sync_edge_det.sv
// Synchroniser plus rising-edge detector for an asynchronous input.
// Pulse appears SYNC_STAGES cycles after the input rises and is consumed
// by the next clock edge, giving SYNC_STAGES+1 cycles of latency.
`timescale 1ps/1ps
module sync_edge_det #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic rise_pulse
);

   logic [SYNC_STAGES-1:0] sync_chain;
   logic                   sync_prev;

   // Metastability chain followed by one history flop for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_chain <= '0;
         sync_prev  <= 1'b0;
      end else begin
         sync_chain <= {sync_chain[SYNC_STAGES-2:0], async_in};
         sync_prev  <= sync_chain[SYNC_STAGES-1];
      end
   end

   assign rise_pulse = sync_chain[SYNC_STAGES-1] & ~sync_prev;

endmodule

// File: rtl/ring_freq_meter.sv
// Gated edge counter for a ring oscillator: enables the oscillator, waits for
// it to settle, counts synchronised rising edges over GATE_CYCLES clocks and
// publishes the saturating count with a one-cycle valid pulse.
`timescale 1ps/1ps
module ring_freq_meter
   import ring_pkg::*;
#(
   parameter int GATE_CYCLES   = DEF_GATE_CYCLES,
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   parameter int CNT_W         = DEF_CNT_W,
   parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             osc_in,
   output logic             osc_en,
   output logic             busy,
   output logic [CNT_W-1:0] count_out,
   output logic             count_valid,
   output logic             overflow
);

   localparam int GATE_W   = $clog2(GATE_CYCLES);
   localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t              state;
   logic [SETTLE_W-1:0] settle_cnt;
   logic [GATE_W-1:0]   gate_cnt;
   logic [CNT_W-1:0]    edge_cnt;
   logic                sat_flag;
   logic                rise;
   logic                at_max;
   logic [CNT_W-1:0]    edge_cnt_upd;
   logic                sat_upd;

   sync_edge_det #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk        (clk),
      .rst_n      (rst_n),
      .async_in   (osc_in),
      .rise_pulse (rise)
   );

   // Saturating increment: an edge arriving at full scale is lost and flagged
   always_comb begin
      at_max       = (edge_cnt == CNT_MAX);
      edge_cnt_upd = edge_cnt;
      sat_upd      = sat_flag;
      if (rise) begin
         if (at_max) sat_upd = 1'b1;
         else        edge_cnt_upd = edge_cnt + CNT_W'(1);
      end
   end

   // Measurement sequencer with registered outputs; abort wins over window end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         settle_cnt  <= '0;
         gate_cnt    <= '0;
         edge_cnt    <= '0;
         sat_flag    <= 1'b0;
         osc_en      <= 1'b0;
         busy        <= 1'b0;
         count_out   <= '0;
         count_valid <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         count_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start && !abort) begin
                  state      <= ST_SETTLE;
                  settle_cnt <= SETTLE_W'(SETTLE_CYCLES - 1);
                  osc_en     <= 1'b1;
                  busy       <= 1'b1;
               end
            end
            ST_SETTLE: begin
               if (abort) begin
                  state  <= ST_IDLE;
                  osc_en <= 1'b0;
                  busy   <= 1'b0;
               end else if (settle_cnt == '0) begin
                  state    <= ST_MEASURE;
                  gate_cnt <= GATE_W'(GATE_CYCLES - 1);
                  edge_cnt <= '0;
                  sat_flag <= 1'b0;
               end else begin
                  settle_cnt <= settle_cnt - SETTLE_W'(1);
               end
            end
            ST_MEASURE: begin
               if (abort) begin
                  state  <= ST_IDLE;
                  osc_en <= 1'b0;
                  busy   <= 1'b0;
               end else begin
                  edge_cnt <= edge_cnt_upd;
                  sat_flag <= sat_upd;
                  if (gate_cnt == '0) begin
                     state       <= ST_DONE;
                     count_out   <= edge_cnt_upd;
                     overflow    <= sat_upd;
                     count_valid <= 1'b1;
                     osc_en      <= 1'b0;
                     busy        <= 1'b0;
                  end else begin
                     gate_cnt <= gate_cnt - GATE_W'(1);
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ring_freq_meter.sv
// Self-checking bench: table-driven measurement scenarios with a scoreboard
// of expected results, plus hand sequences for multi-cycle corner cases.
`timescale 1ps/1ps
module tb_ring_freq_meter;
   import ring_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n, start, abort, osc_in, osc_en, busy, count_valid, overflow;
   logic [15:0] count_out;
   logic        start_b, abort_b, osc_in_b, osc_en_b, busy_b, count_valid_b, overflow_b;
   logic [5:0]  count_out_b;

   logic osc_a = 1'b0, osc_b = 1'b0, manual_mode = 1'b0, manual_osc = 1'b0;

   always #5000 clk = ~clk;

   // Three-stage ring, 8330 ps per inverter -> 49980 ps period
   always begin
      if (osc_en === 1'b1) begin
         #24990;
         if (osc_en === 1'b1) osc_a = ~osc_a;
      end else begin
         osc_a = 1'b0;
         @(posedge osc_en);
      end
   end

   always begin
      if (osc_en_b === 1'b1) begin
         #24990;
         if (osc_en_b === 1'b1) osc_b = ~osc_b;
      end else begin
         osc_b = 1'b0;
         @(posedge osc_en_b);
      end
   end

   assign osc_in   = manual_mode ? manual_osc : osc_a;
   assign osc_in_b = osc_b;

   ring_freq_meter dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .osc_in(osc_in),
      .osc_en(osc_en), .busy(busy), .count_out(count_out),
      .count_valid(count_valid), .overflow(overflow)
   );

   ring_freq_meter #(.CNT_W(6)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .osc_in(osc_in_b),
      .osc_en(osc_en_b), .busy(busy_b), .count_out(count_out_b),
      .count_valid(count_valid_b), .overflow(overflow_b)
   );

   typedef struct {int lo; int hi; bit ovf;} exp_t;
   typedef struct {int abort_at; bit restart; int edge_at; int lo; int hi; bit valid;} vec_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_err = 0;
   int   last_lo = 0;
   int   last_hi = 0;
   localparam int MEAS_LAT = DEF_SETTLE_CYCLES + DEF_GATE_CYCLES;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_range(input string name, input logic [31:0] act, input int lo, input int hi);
      n_cmp++;
      if ($isunknown(act) || int'(act) < lo || int'(act) > hi) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: got no count_valid within bound, expected one pulse", name);
   endtask

   // Scoreboard consumer: every count_valid must match a queued expectation
   always @(negedge clk) begin
      if (rst_n === 1'b1 && count_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_valid: got count_valid=1 count_out=%0d, expected no pulse", count_out);
         end else begin
            mon_e = sb_q.pop_front();
            $display("txn: count_out=%0d overflow=%0d expected %0d..%0d ovf=%0d",
                     count_out, overflow, mon_e.lo, mon_e.hi, mon_e.ovf);
            chk_range("count_out", count_out, mon_e.lo, mon_e.hi);
            chk("overflow", overflow, mon_e.ovf);
         end
      end
   end

   // One measurement scenario; cycle index k counts negedges after the start edge
   task automatic run_vec(input vec_t v, input int idx);
      int k;
      bit got;
      got = 1'b0;
      manual_osc  = 1'b0;
      manual_mode = (v.edge_at >= 0);
      repeat (5) @(negedge clk);
      if (v.valid) sb_q.push_back('{v.lo, v.hi, 1'b0});
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      k = 0;
      chk("busy_after_start", busy, 1'b1);
      chk("osc_en_after_start", osc_en, 1'b1);
      while (k < 1200 && !got) begin
         start = v.restart && (k == 20 || k == 500);
         abort = (k == v.abort_at);
         if (v.edge_at >= 0 && k == v.edge_at) manual_osc = 1'b1;
         @(negedge clk);
         k++;
         if (count_valid === 1'b1) begin
            got = 1'b1;
            chk("valid_latency", k, MEAS_LAT);
            chk("busy_in_done", busy, 1'b0);
            chk("osc_en_in_done", osc_en, 1'b0);
         end
         if (v.abort_at >= 0 && k == v.abort_at + 1) begin
            chk("abort_osc_en", osc_en, 1'b0);
            chk("abort_busy", busy, 1'b0);
            chk_range("abort_count_hold", count_out, last_lo, last_hi);
            chk("abort_overflow_hold", overflow, 1'b0);
         end
         if (v.abort_at >= 0 && k == v.abort_at + 10) break;
      end
      start = 1'b0;
      abort = 1'b0;
      if (v.valid && !got) timeout_fail($sformatf("vec%0d_timeout", idx));
      if (v.valid) begin
         last_lo = v.lo;
         last_hi = v.hi;
      end
      manual_osc = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      int k;
      k = 0;
      while (count_valid !== 1'b1 && k < 1200) begin
         @(negedge clk);
         k++;
      end
      if (count_valid !== 1'b1) timeout_fail(name);
   endtask

   vec_t vecs [8];

   initial begin
      // abort_at, restart, edge_at, lo, hi, valid
      vecs[0] = '{-1,  1'b0, -1,   200, 201, 1'b1}; // free-running oscillator
      vecs[1] = '{364, 1'b0, -1,   0,   0,   1'b0}; // abort at gate cycle 300
      vecs[2] = '{-1,  1'b1, -1,   200, 201, 1'b1}; // start re-pulsed mid-run
      vecs[3] = '{-1,  1'b0, 1061, 1,   1,   1'b1}; // edge lands on last gate cycle
      vecs[4] = '{10,  1'b0, -1,   0,   0,   1'b0}; // abort during settle
      vecs[5] = '{-1,  1'b0, 1062, 0,   0,   1'b1}; // edge lands in DONE
      vecs[6] = '{-1,  1'b0, 62,   1,   1,   1'b1}; // edge on first gate cycle
      vecs[7] = '{-1,  1'b0, 61,   0,   0,   1'b1}; // edge still in settle

      rst_n = 1'b1; start = 1'b0; abort = 1'b0; start_b = 1'b0; abort_b = 1'b0;
      #1000 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_osc_en", osc_en, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_count_out", count_out, 16'd0);
      chk("rst_count_valid", count_valid, 1'b0);
      chk("rst_overflow", overflow, 1'b0);
      @(negedge clk) rst_n = 1'b1;
      repeat (5) @(negedge clk);

      for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

      // start during DONE is ignored, start in the following IDLE cycle is accepted
      manual_mode = 1'b0;
      repeat (5) @(negedge clk);
      sb_q.push_back('{200, 201, 1'b0});
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      wait_valid("b2b_first_timeout");
      start = 1'b1;
      @(negedge clk);
      chk("start_in_done_ignored", busy, 1'b0);
      @(negedge clk);
      start = 1'b0;
      chk("b2b_start_accepted", busy, 1'b1);
      sb_q.push_back('{200, 201, 1'b0});
      @(negedge clk);
      wait_valid("b2b_second_timeout");
      repeat (5) @(negedge clk);

      // start together with abort in IDLE keeps the meter idle
      @(negedge clk) begin start = 1'b1; abort = 1'b1; end
      @(negedge clk) begin start = 1'b0; abort = 1'b0; end
      chk("start_abort_idle_busy", busy, 1'b0);
      chk("start_abort_idle_osc_en", osc_en, 1'b0);

      // reset at gate cycle 500 clears everything without waiting for a clock
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (564) @(negedge clk);
      #2000 rst_n = 1'b0;
      #1;
      chk("midrst_osc_en", osc_en, 1'b0);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_count_out", count_out, 16'd0);
      chk("midrst_count_valid", count_valid, 1'b0);
      chk("midrst_overflow", overflow, 1'b0);
      @(negedge clk) rst_n = 1'b1;
      last_lo = 0;
      last_hi = 0;
      repeat (3) @(negedge clk);
      chk("postrst_busy", busy, 1'b0);
      chk("postrst_count_out", count_out, 16'd0);
      run_vec(vecs[0], 8);

      // 6-bit counter against ~200 edges saturates
      repeat (5) @(negedge clk);
      @(negedge clk) start_b = 1'b1;
      @(negedge clk) start_b = 1'b0;
      begin
         int k;
         k = 0;
         while (count_valid_b !== 1'b1 && k < 1200) begin
            @(negedge clk);
            k++;
         end
         if (count_valid_b !== 1'b1) timeout_fail("sat_timeout");
      end
      $display("txn: sat count_out=%0d overflow=%0d", count_out_b, overflow_b);
      chk("sat_count_out", count_out_b, 6'd63);
      chk("sat_overflow", overflow_b, 1'b1);
      @(negedge clk);
      chk("sat_valid_one_cycle", count_valid_b, 1'b0);

      repeat (5) @(negedge clk);
      chk("scoreboard_drained", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
